nts_tx_arbiter: RTL
===================

# nts_tx_arbiter

Round-robin scheduler that shares the single MAC TX path between all NTS and mini engines. It watches each engine's packet-available flag, grants one engine at a time to the extractor, and waits for the extractor to report completion. On completion it issues the engine's one-cycle packet-read acknowledge. A watchdog aborts a grant that never completes. It sits between the engine array and the extractor, replacing ad-hoc selection inside the extractor.

## Interface
- ENGINES, 18: number of requesting engines (NTS + mini).
- TIMEOUT_CYCLES, 4096: maximum cycles in WAIT_DONE before the grant is aborted.
- HOLDOFF_CYCLES, 2: guard cycles after release, letting the released engine drop its request.
- i_clk  in  1  system clock.
- i_areset  in  1  reset, synchronous, active-high (name kept for codebase consistency).
- i_enable  in  1  when low, no new grants; an active grant runs to completion or timeout.
- i_engine_packet_available  in  ENGINES  per-engine TX packet ready.
- o_engine_packet_read  out  ENGINES  one-hot, one-cycle acknowledge to the granted engine.
- o_grant_valid  out  1  a grant is active.
- o_grant_index  out  IDX_W  granted engine index; IDX_W = max(1, clog2(ENGINES)).
- i_grant_ready  in  1  extractor accepts the grant and starts the transfer.
- i_tx_done  in  1  one-cycle pulse: extractor finished sending the granted packet.
- o_timeout  out  1  one-cycle pulse on watchdog abort.
- o_stat_grants  out  32  completed grants (STATS build only).
- o_stat_timeouts  out  32  aborted grants (STATS build only).

## Operation
- Reset values:
  - all outputs 0;
  - state IDLE;
  - rr_ptr 0;
  - counters 0.
- IDLE:
  - Entered when i_enable=1 and any request is set.
  - Selects the first set bit at or after rr_ptr, wrapping from ENGINES-1 to 0.
  - Registers the selected index into o_grant_index, sets o_grant_valid, moves to OFFER.
- OFFER:
  - o_grant_valid=1 and o_grant_index are held stable.
  - When i_grant_ready=1, the watchdog is cleared and the state moves to WAIT_DONE.
  - OFFER has no timeout.
- WAIT_DONE:
  - o_grant_valid stays 1. The watchdog increments every cycle.
  - On i_tx_done: pulse o_engine_packet_read[grant_index] for the next cycle, increment stat_grants, move to HOLDOFF.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without i_tx_done: pulse o_timeout, increment stat_timeouts, move to HOLDOFF. No packet_read is issued.
  - If i_tx_done and the timeout occur in the same cycle, i_tx_done wins.
- HOLDOFF:
  - o_grant_valid=0.
  - rr_ptr = grant_index+1, wrapping at ENGINES-1 to 0.
  - Waits HOLDOFF_CYCLES, then returns to IDLE.
- Ignored inputs:
  - i_tx_done outside WAIT_DONE is ignored.
  - i_grant_ready outside OFFER is ignored.
- A request that drops while in OFFER does not withdraw the grant; the extractor's timeout path covers that case.
- Stat counters saturate at 0xFFFFFFFF.

## Timing
- A request seen in cycle N while in IDLE gives o_grant_valid=1 in cycle N+1.
- i_grant_ready in cycle M gives WAIT_DONE in cycle M+1.
- i_tx_done in cycle K gives o_engine_packet_read high in cycle K+1 only, and o_grant_valid low in K+1.
- HOLDOFF then occupies K+1 to K+HOLDOFF_CYCLES. The next o_grant_valid comes no earlier than K+HOLDOFF_CYCLES+2.
- A timeout raises o_timeout exactly TIMEOUT_CYCLES cycles after the WAIT_DONE entry cycle.
- Reset asserted mid-grant: the next cycle has all outputs 0, state IDLE, rr_ptr 0, and no packet_read pulse.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- NTS_TX_ARBITER_STATS_EN defined:
  - o_stat_grants and o_stat_timeouts are live saturating 32-bit counters.
  - Counters clear only on reset.
- NTS_TX_ARBITER_STATS_EN undefined:
  - both stat outputs are tied to 0 and no counter flops are inferred.
  - All other behaviour is identical.

## Structure
- Shared package nts_tx_arbiter_pkg holds:
  - the state enum (IDLE, OFFER, WAIT_DONE, HOLDOFF);
  - the idx-width function;
  - default constants TIMEOUT_CYCLES and HOLDOFF_CYCLES.
- One sub-module, nts_rr_select: a purely combinational rotate-priority encoder (request vector, rr_ptr → found, index). It is reusable by the dispatcher.

## Test plan
- Single request: ENGINES=18, bit 5 set. Expect o_grant_index=5 one cycle later. Ready, then done → o_engine_packet_read=1<<5 for exactly 1 cycle, o_stat_grants=1.
- Round-robin: bits 0, 3 and 17 held high across three grants. Expect order 0, 3, 17, then wrap back to 0.
- Timeout: ready given, done withheld. Expect o_timeout exactly 4096 cycles after WAIT_DONE entry, no packet_read, o_stat_timeouts=1, next grant goes to the following engine.
- Simultaneous: i_tx_done on the final watchdog cycle. Expect packet_read and no o_timeout.
- Sticky request / holdoff: engine 2 drops its request 1 cycle after packet_read. Expect no regrant of 2 during HOLDOFF.
- Reset in WAIT_DONE with i_enable=0, then re-enable: after reset all outputs are 0; a request at bit 4 is granted only after i_enable returns to 1, with rr_ptr starting from 0.

Source files
------------

// File: rtl/nts_tx_arbiter_pkg.sv
// Shared types and defaults for the NTS TX arbiter and its round-robin selector.
// Used by nts_tx_arbiter and nts_rr_select.
package nts_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OFFER     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLDOFF   = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
  localparam int DEFAULT_HOLDOFF_CYCLES = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nts_rr_select.sv
// Combinational rotate-priority encoder: first set request at or after ptr,
// wrapping from N-1 back to 0.
module nts_rr_select
  import nts_tx_arbiter_pkg::*;
#(
  parameter int N = 18,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  int c;

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    found = 1'b0;
    index = '0;
    c     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (req[c]) begin
        found = 1'b1;
        index = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/nts_tx_arbiter.sv
// Round-robin owner of the MAC TX path across NTS and mini engines, with watchdog.
// Optional NTS_TX_ARBITER_STATS_EN enables saturating grant/timeout counters.
module nts_tx_arbiter
  import nts_tx_arbiter_pkg::*;
#(
  parameter int ENGINES        = 18,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES,
  localparam int IDX_W = idx_w(ENGINES)
) (
  input  logic               i_clk,
  input  logic               i_areset,
  input  logic               i_enable,
  input  logic [ENGINES-1:0] i_engine_packet_available,
  output logic [ENGINES-1:0] o_engine_packet_read,
  output logic               o_grant_valid,
  output logic [IDX_W-1:0]   o_grant_index,
  input  logic               i_grant_ready,
  input  logic               i_tx_done,
  output logic               o_timeout,
  output logic [31:0]        o_stat_grants,
  output logic [31:0]        o_stat_timeouts,
  output logic [1:0]         o_dbg_state
);

  // Handshake: the grant is offered with o_grant_valid/o_grant_index held
  // stable until i_grant_ready is seen high in OFFER; completion is the
  // i_tx_done pulse in WAIT_DONE, acknowledged to the engine one cycle later.

  localparam int WD_W = idx_w(TIMEOUT_CYCLES + 1);
  localparam int HO_W = idx_w(HOLDOFF_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  // HOLDOFF_CYCLES must be at least 1.
  localparam logic [HO_W-1:0] HOLD_LAST = HO_W'(HOLDOFF_CYCLES - 1);

  arb_state_e        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [WD_W-1:0]   wd_cnt;
  logic [HO_W-1:0]   hold_cnt;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_index;
  logic              done_hit;
  logic              wd_expired;
  logic [IDX_W-1:0]  next_ptr;

  nts_rr_select #(
    .N(ENGINES)
  ) u_rr_select (
    .req   (i_engine_packet_available),
    .ptr   (rr_ptr),
    .found (sel_found),
    .index (sel_index)
  );

  assign done_hit   = (state == ST_WAIT_DONE) && i_tx_done;
  assign wd_expired = (state == ST_WAIT_DONE) && !i_tx_done && (wd_cnt == WD_LAST);
  assign next_ptr   = (o_grant_index == IDX_W'(ENGINES - 1)) ? '0
                                                               : o_grant_index + IDX_W'(1);
  assign o_dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state                <= ST_IDLE;
      rr_ptr               <= '0;
      wd_cnt               <= '0;
      hold_cnt             <= '0;
      o_grant_valid        <= 1'b0;
      o_grant_index        <= '0;
      o_engine_packet_read <= '0;
      o_timeout            <= 1'b0;
    end else begin
      o_engine_packet_read <= '0;
      o_timeout            <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_enable && sel_found) begin
            o_grant_index <= sel_index;
            o_grant_valid <= 1'b1;
            state         <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (i_grant_ready) begin
            wd_cnt <= '0;
            state  <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // Completion takes priority over an expiring watchdog.
          if (done_hit) begin
            o_engine_packet_read <= ENGINES'(1) << o_grant_index;
            o_grant_valid        <= 1'b0;
            rr_ptr               <= next_ptr;
            hold_cnt             <= '0;
            state                <= ST_HOLDOFF;
          end else if (wd_expired) begin
            o_timeout     <= 1'b1;
            o_grant_valid <= 1'b0;
            rr_ptr        <= next_ptr;
            hold_cnt      <= '0;
            state         <= ST_HOLDOFF;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NTS_TX_ARBITER_STATS_EN
  logic [31:0] stat_grants;
  logic [31:0] stat_timeouts;

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      stat_grants   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (done_hit && (stat_grants != 32'hFFFF_FFFF)) stat_grants <= stat_grants + 1'b1;
      if (wd_expired && (stat_timeouts != 32'hFFFF_FFFF)) stat_timeouts <= stat_timeouts + 1'b1;
    end
  end

  assign o_stat_grants   = stat_grants;
  assign o_stat_timeouts = stat_timeouts;
`else
  assign o_stat_grants   = '0;
  assign o_stat_timeouts = '0;
`endif

endmodule
